// File: rtl/axis_packet_arbiter.sv
// ---------------------------------------------------------------------------
// axis_packet_arbiter
//
// Packet-level round-robin arbiter that merges NIN AXI-Stream slave inputs
// onto one AXI-Stream master output. A granted input keeps the output until
// its TLAST beat is accepted, so packets from different inputs never
// interleave. One IDLE cycle is spent arbitrating between packets.
//
// Ports:
//   i_aclk          clock, all logic on the rising edge
//   i_aresetn       synchronous active-low reset
//   S_AXIS_TVALID   per-input valid                       [NIN]
//   S_AXIS_TREADY   per-input ready (at most one high)    [NIN]
//   S_AXIS_TDATA    input n at [n*DW +: DW]               [NIN*DW]
//   S_AXIS_TLAST    per-input end of packet               [NIN]
//   S_AXIS_TUSER    input n at [n*UW +: UW]               [NIN*UW]
//   M_AXIS_TVALID   registered output valid
//   M_AXIS_TREADY   downstream ready
//   M_AXIS_TDATA    registered output data                [DW]
//   M_AXIS_TLAST    registered output last
//   M_AXIS_TUSER    registered output user                [UW]
//   M_AXIS_TID      index of the input that sourced the beat [LGNIN]
//   o_busy          high while an input holds the lock
// ---------------------------------------------------------------------------
module axis_packet_arbiter #(
    parameter  int NIN   = 4,
    parameter  int DW    = 32,
    parameter  int UW    = 1,
    localparam int LGNIN = $clog2(NIN)
) (
    input  logic                 i_aclk,
    input  logic                 i_aresetn,
    input  logic [NIN-1:0]       S_AXIS_TVALID,
    output logic [NIN-1:0]       S_AXIS_TREADY,
    input  logic [NIN*DW-1:0]    S_AXIS_TDATA,
    input  logic [NIN-1:0]       S_AXIS_TLAST,
    input  logic [NIN*UW-1:0]    S_AXIS_TUSER,
    output logic                 M_AXIS_TVALID,
    input  logic                 M_AXIS_TREADY,
    output logic [DW-1:0]        M_AXIS_TDATA,
    output logic                 M_AXIS_TLAST,
    output logic [UW-1:0]        M_AXIS_TUSER,
    output logic [LGNIN-1:0]     M_AXIS_TID,
    output logic                 o_busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_r;
    logic [LGNIN-1:0] grant_r;
    logic [LGNIN-1:0] last_grant_r;

    logic             m_valid_r;
    logic [DW-1:0]    m_data_r;
    logic             m_last_r;
    logic [UW-1:0]    m_user_r;
    logic [LGNIN-1:0] m_tid_r;

    logic [NIN-1:0]   tready_s;
    logic             accept_s;
    logic [DW-1:0]    sel_data_s;
    logic             sel_last_s;
    logic [UW-1:0]    sel_user_s;

    // First requester strictly after 'last', wrapping modulo NIN, so the
    // most recently served input has the lowest priority.
    function automatic logic [LGNIN-1:0] rr_pick(input logic [NIN-1:0]   req,
                                                 input logic [LGNIN-1:0] last);
        logic [LGNIN-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NIN; i++) begin
            idx = (int'(last) + i) % NIN;
            if (!found && req[idx[LGNIN-1:0]]) begin
                pick  = idx[LGNIN-1:0];
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Only the locked input may see ready, and only when the output
    // register is empty or being drained this cycle.
    always_comb begin
        tready_s = '0;
        if (state_r == ST_LOCKED) begin
            tready_s[grant_r] = !m_valid_r || M_AXIS_TREADY;
        end else begin
            tready_s = '0;
        end
    end

    assign accept_s   = S_AXIS_TVALID[grant_r] && tready_s[grant_r];
    assign sel_data_s = S_AXIS_TDATA[grant_r*DW +: DW];
    assign sel_last_s = S_AXIS_TLAST[grant_r];
    assign sel_user_s = S_AXIS_TUSER[grant_r*UW +: UW];

    // Arbitration FSM: grant in IDLE, release the lock on an accepted TLAST.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= LGNIN'(NIN - 1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|S_AXIS_TVALID) begin
                        grant_r <= rr_pick(S_AXIS_TVALID, last_grant_r);
                        state_r <= ST_LOCKED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (accept_s && sel_last_s) begin
                        state_r      <= ST_IDLE;
                        last_grant_r <= grant_r;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: load on accept, drain on downstream ready, else hold.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_last_r  <= 1'b0;
            m_user_r  <= '0;
            m_tid_r   <= '0;
        end else if (accept_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= sel_data_s;
            m_last_r  <= sel_last_s;
            m_user_r  <= sel_user_s;
            m_tid_r   <= grant_r;
        end else if (M_AXIS_TREADY) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    assign S_AXIS_TREADY = tready_s;
    assign M_AXIS_TVALID = m_valid_r;
    assign M_AXIS_TDATA  = m_data_r;
    assign M_AXIS_TLAST  = m_last_r;
    assign M_AXIS_TUSER  = m_user_r;
    assign M_AXIS_TID    = m_tid_r;
    assign o_busy        = (state_r == ST_LOCKED);

endmodule
